// File: rtl/leaf_packetizer_pkg.sv
// Shared definitions for the leaf packetizer: packet field layout,
// inbound control port codes and the sender FSM states.
package leaf_packetizer_pkg;

    localparam int VALID_BIT   = 48;
    localparam int LEAF_LSB    = 43;
    localparam int LEAF_W      = 5;
    localparam int PORT_LSB    = 39;
    localparam int PORT_W      = 4;
    localparam int ADDR_LSB    = 32;
    localparam int ADDR_W      = 7;
    localparam int PAYLOAD_LSB = 0;
    localparam int PAYLOAD_W   = 32;

    // Destination fields carried inside a config packet payload
    localparam int CFG_PORT_LSB = 0;
    localparam int CFG_LEAF_LSB = 4;

    localparam int CFG_PORT    = 0;
    localparam int CREDIT_PORT = 1;

    typedef enum logic [1:0] {
        UNCFG,
        RUN,
        NOCRED
    } state_e;

endpackage

// File: rtl/leaf_credit_counter.sv
// Saturating credit counter: reload, bulk add and single-word decrement
// resolved in one cycle, with current and next-cycle zero flags.
module leaf_credit_counter #(
    parameter int CREDIT_BITS = 8,
    parameter int MAX_CREDIT  = 128,
    parameter int UPDATE_SIZE = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic add_i,
    input  logic dec_i,
    output logic zero_o,
    output logic next_zero_o
);

    localparam logic [CREDIT_BITS:0] MAX_W = (CREDIT_BITS+1)'(MAX_CREDIT);
    localparam logic [CREDIT_BITS:0] UPD_W = (CREDIT_BITS+1)'(UPDATE_SIZE);
    localparam logic [CREDIT_BITS:0] ONE_W = (CREDIT_BITS+1)'(1);

    logic [CREDIT_BITS-1:0] credit_q;
    logic [CREDIT_BITS-1:0] credit_d;
    logic [CREDIT_BITS:0]   sum;

    // Add before subtract so a coincident update and send nets +63
    always_comb begin
        sum = {1'b0, credit_q};
        if (add_i) begin
            sum = sum + UPD_W;
        end
        if (dec_i && sum != '0) begin
            sum = sum - ONE_W;
        end
        if (sum > MAX_W) begin
            sum = MAX_W;
        end
        credit_d = load_i ? MAX_W[CREDIT_BITS-1:0] : sum[CREDIT_BITS-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= '0;
        end else begin
            credit_q <= credit_d;
        end
    end

    assign zero_o      = (credit_q == '0);
    assign next_zero_o = (credit_d == '0);

endmodule

// File: rtl/leaf_packetizer.sv
// Leaf interface: wraps user words into BFT packets towards a configured
// destination, flow-controlled by credits returned from the far BRAM.
module leaf_packetizer
    import leaf_packetizer_pkg::*;
#(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                    clk,
    input  logic                    ap_rst_n,
    input  logic [PAYLOAD_BITS-1:0] din_leaf_user2interface,
    input  logic                    vld_user2interface,
    output logic                    ack_interface2user,
    input  logic [PACKET_BITS-1:0]  din_leaf_bft2interface,
    output logic [PACKET_BITS-1:0]  dout_leaf_interface2bft,
    input  logic                    bft_ready,
    output logic                    cfg_done
);

    state_e                   state_q, state_d;
    logic [NUM_LEAF_BITS-1:0] leaf_q, leaf_d;
    logic [NUM_PORT_BITS-1:0] port_q, port_d;
    logic [NUM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [PACKET_BITS-1:0]   pkt_q, pkt_d;

    logic                     in_vld;
    logic [NUM_PORT_BITS-1:0] in_port;
    logic                     is_cfg;
    logic                     is_upd;
    logic                     accept;
    logic                     cred_zero;
    logic                     cred_next_zero;
    logic                     unused_ok;

    assign in_vld  = din_leaf_bft2interface[VALID_BIT];
    assign in_port = din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS];
    assign is_cfg  = in_vld && (in_port == NUM_PORT_BITS'(CFG_PORT));
    assign is_upd  = in_vld && (in_port == NUM_PORT_BITS'(CREDIT_PORT));

    assign unused_ok = ^{din_leaf_bft2interface[PACKET_BITS-2:PORT_LSB+NUM_PORT_BITS],
                         din_leaf_bft2interface[PORT_LSB-1:CFG_LEAF_LSB+NUM_LEAF_BITS]};

    assign ack_interface2user = (state_q == RUN) && !cred_zero &&
                                (!pkt_q[VALID_BIT] || bft_ready);
    assign accept   = ack_interface2user && vld_user2interface;
    assign cfg_done = (state_q != UNCFG);
    assign dout_leaf_interface2bft = pkt_q;

    leaf_credit_counter #(
        .CREDIT_BITS (8),
        .MAX_CREDIT  (2 ** NUM_ADDR_BITS),
        .UPDATE_SIZE (FREESPACE_UPDATE_SIZE)
    ) u_credit (
        .clk         (clk),
        .rst_n       (ap_rst_n),
        .load_i      (is_cfg),
        .add_i       (is_upd),
        .dec_i       (accept),
        .zero_o      (cred_zero),
        .next_zero_o (cred_next_zero)
    );

    always_comb begin
        state_d = state_q;
        leaf_d  = leaf_q;
        port_d  = port_q;
        addr_d  = addr_q;
        pkt_d   = pkt_q;

        // The accepted word always carries the destination held before this edge
        if (accept) begin
            pkt_d = {1'b1, leaf_q, port_q, addr_q, din_leaf_user2interface};
        end else if (bft_ready) begin
            pkt_d = '0;
        end

        if (is_cfg) begin
            leaf_d = din_leaf_bft2interface[CFG_LEAF_LSB +: NUM_LEAF_BITS];
            port_d = din_leaf_bft2interface[CFG_PORT_LSB +: NUM_PORT_BITS];
            addr_d = '0;
        end else if (accept) begin
            addr_d = addr_q + 1'b1;
        end

        if (is_cfg) begin
            state_d = RUN;
        end else if (state_q == RUN && cred_next_zero) begin
            state_d = NOCRED;
        end else if (state_q == NOCRED && !cred_next_zero) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= UNCFG;
            leaf_q  <= '0;
            port_q  <= '0;
            addr_q  <= '0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            leaf_q  <= leaf_d;
            port_q  <= port_d;
            addr_q  <= addr_d;
            pkt_q   <= pkt_d;
        end
    end

endmodule

// File: tb/tb_leaf_packetizer.sv
// Directed bench for leaf_packetizer: a credit/address model is checked
// against the DUT every cycle, plus literal checks of key scenarios.
module tb_leaf_packetizer;

    logic        clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [31:0] din_user = '0;
    logic        vld = 1'b0;
    logic        ack;
    logic [48:0] din_bft = '0;
    logic [48:0] dout;
    logic        bft_ready = 1'b0;
    logic        cfg_done;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    leaf_packetizer dut (
        .clk                     (clk),
        .ap_rst_n                (ap_rst_n),
        .din_leaf_user2interface (din_user),
        .vld_user2interface      (vld),
        .ack_interface2user      (ack),
        .din_leaf_bft2interface  (din_bft),
        .dout_leaf_interface2bft (dout),
        .bft_ready               (bft_ready),
        .cfg_done                (cfg_done)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [48:0] mkpkt(input logic [3:0] port,
                                          input logic [31:0] pl);
        return {1'b1, 5'd0, port, 7'd0, pl};
    endfunction

    // Model state: configured flag, credit, next address, destination,
    // and the packet that should be presented to the BFT.
    bit          m_cfg = 0,  n_cfg = 0;
    int          m_credit = 0, n_credit = 0;
    int          m_addr = 0, n_addr = 0;
    logic [4:0]  m_leaf = '0, n_leaf = '0;
    logic [3:0]  m_port = '0, n_port = '0;
    logic [48:0] m_pkt = '0, n_pkt = '0;

    int acc_cnt = 0;
    int dlv_addr[$];

    always @(negedge clk) begin
        bit m_ack, acc, upd, cfg;
        if (!ap_rst_n) begin
            m_cfg = 0; m_credit = 0; m_addr = 0;
            m_leaf = '0; m_port = '0; m_pkt = '0;
        end
        m_ack = m_cfg && m_credit > 0 && (!m_pkt[48] || bft_ready);
        chk("ack", 64'(ack), 64'(m_ack));
        chk("cfg_done", 64'(cfg_done), 64'(m_cfg));
        chk("dout_valid", 64'(dout[48]), 64'(m_pkt[48]));
        if (m_pkt[48]) chk("dout_pkt", 64'(dout), 64'(m_pkt));

        if (ap_rst_n) begin
            if (vld && ack) acc_cnt++;
            if (dout[48] && bft_ready) dlv_addr.push_back(int'(dout[38:32]));
        end

        acc = m_ack && vld;
        cfg = din_bft[48] && din_bft[42:39] == 4'd0;
        upd = din_bft[48] && din_bft[42:39] == 4'd1;
        if (acc) n_pkt = {1'b1, m_leaf, m_port, 7'(m_addr), din_user};
        else if (bft_ready) n_pkt = '0;
        else n_pkt = m_pkt;
        n_cfg = m_cfg; n_leaf = m_leaf; n_port = m_port;
        if (cfg) begin
            n_cfg = 1; n_credit = 128; n_addr = 0;
            n_leaf = din_bft[8:4]; n_port = din_bft[3:0];
        end else begin
            n_credit = m_credit + (upd ? 64 : 0) - (acc ? 1 : 0);
            if (n_credit > 128) n_credit = 128;
            n_addr = acc ? (m_addr + 1) % 128 : m_addr;
        end
    end

    always @(posedge clk) begin
        if (ap_rst_n) begin
            m_cfg = n_cfg; m_credit = n_credit; m_addr = n_addr;
            m_leaf = n_leaf; m_port = n_port; m_pkt = n_pkt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input logic [31:0] pl);
        din_bft = mkpkt(4'd0, pl);
        tick();
        din_bft = '0;
    endtask

    initial begin
        int acc0;
        logic [48:0] exp;

        repeat (3) tick();
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_cfg", 64'(cfg_done), 64'd0);
        bft_ready = 1'b1;
        ap_rst_n = 1'b1;
        repeat (2) tick();

        din_bft = mkpkt(4'd5, 32'h53);
        tick();
        din_bft = '0;
        chk("ignored_port_cfg", 64'(cfg_done), 64'd0);

        send_cfg(32'h0000_0053);
        chk("cfg_done_after_cfg", 64'(cfg_done), 64'd1);
        chk("ack_after_cfg", 64'(ack), 64'd1);

        acc0 = acc_cnt;
        dlv_addr.delete();
        vld = 1'b1;
        for (int i = 0; i < 130; i++) begin
            din_user = 32'h1000 + i;
            tick();
        end
        vld = 1'b0;
        repeat (2) tick();
        chk("stream_accepts", 64'(acc_cnt - acc0), 64'd128);
        chk("stream_delivered", 64'(dlv_addr.size()), 64'd128);
        chk("stream_first_addr", 64'(dlv_addr[0]), 64'd0);
        chk("stream_last_addr", 64'(dlv_addr[127]), 64'd127);
        chk("nocred_ack", 64'(ack), 64'd0);

        acc0 = acc_cnt;
        dlv_addr.delete();
        din_bft = mkpkt(4'd1, 32'h0);
        tick();
        din_bft = '0;
        chk("ack_after_update", 64'(ack), 64'd1);
        vld = 1'b1;
        for (int i = 0; i < 70; i++) begin
            din_user = 32'h2000 + i;
            tick();
        end
        vld = 1'b0;
        repeat (2) tick();
        chk("update_accepts", 64'(acc_cnt - acc0), 64'd64);
        chk("update_first_addr", 64'(dlv_addr[0]), 64'd0);
        chk("update_last_addr", 64'(dlv_addr[63]), 64'd63);
        chk("update_stall_ack", 64'(ack), 64'd0);

        send_cfg(32'h0000_0053);
        bft_ready = 1'b0;
        vld = 1'b1;
        din_user = 32'h0000_AAAA;
        tick();
        din_user = 32'h0000_BBBB;
        exp = {1'b1, 5'd5, 4'd3, 7'd0, 32'h0000_AAAA};
        for (int i = 0; i < 5; i++) begin
            chk("bp_ack", 64'(ack), 64'd0);
            chk("bp_hold", 64'(dout), 64'(exp));
            tick();
        end
        bft_ready = 1'b1;
        tick();
        vld = 1'b0;
        exp = {1'b1, 5'd5, 4'd3, 7'd1, 32'h0000_BBBB};
        chk("bp_next_word", 64'(dout), 64'(exp));
        tick();
        chk("bp_valid_drop", 64'(dout[48]), 64'd0);

        vld = 1'b1;
        din_user = 32'h0000_CCCC;
        din_bft = mkpkt(4'd0, 32'h0000_00A7);
        tick();
        din_bft = '0;
        exp = {1'b1, 5'd5, 4'd3, 7'd2, 32'h0000_CCCC};
        chk("cfg_coincide_old_dest", 64'(dout), 64'(exp));
        din_user = 32'h0000_DDDD;
        tick();
        vld = 1'b0;
        exp = {1'b1, 5'd10, 4'd7, 7'd0, 32'h0000_DDDD};
        chk("cfg_coincide_new_dest", 64'(dout), 64'(exp));

        vld = 1'b1;
        for (int i = 0; i < 126; i++) begin
            din_user = 32'h3000 + i;
            tick();
        end
        chk("credit1_ack", 64'(ack), 64'd1);
        din_user = 32'h0000_EEEE;
        din_bft = mkpkt(4'd1, 32'h0);
        tick();
        din_bft = '0;
        vld = 1'b0;
        chk("coincide_update_run", 64'(ack), 64'd1);
        acc0 = acc_cnt;
        vld = 1'b1;
        for (int i = 0; i < 70; i++) begin
            din_user = 32'h4000 + i;
            tick();
        end
        vld = 1'b0;
        tick();
        chk("credit64_accepts", 64'(acc_cnt - acc0), 64'd64);

        send_cfg(32'h0000_0053);
        bft_ready = 1'b0;
        vld = 1'b1;
        din_user = 32'h0000_5555;
        tick();
        vld = 1'b0;
        chk("pending_before_rst", 64'(dout[48]), 64'd1);
        ap_rst_n = 1'b0;
        #1;
        chk("rst_async_dout", 64'(dout), 64'd0);
        chk("rst_async_ack", 64'(ack), 64'd0);
        tick();
        ap_rst_n = 1'b1;
        bft_ready = 1'b1;
        vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_ack", 64'(ack), 64'd0);
            chk("post_rst_dout_valid", 64'(dout[48]), 64'd0);
        end
        vld = 1'b0;
        chk("post_rst_cfg", 64'(cfg_done), 64'd0);
        send_cfg(32'h0000_0053);
        chk("reconfig_ack", 64'(ack), 64'd1);
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/leaf_packetizer.md
LEAF_PACKETIZER -- requirements
Module: leaf_packetizer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- PACKET_BITS, 49, BFT packet width.
- PAYLOAD_BITS, 32, user data width.
- NUM_LEAF_BITS, 5, destination leaf field width.
- NUM_PORT_BITS, 4, destination port field width.
- NUM_ADDR_BITS, 7, destination BRAM address width.
- FREESPACE_UPDATE_SIZE, 64, credits added per freespace-update packet.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock; all logic on its rising edge.
- ap_rst_n, in, 1, asynchronous active-low reset.
- din_leaf_user2interface, in, PAYLOAD_BITS, user stream data.
- vld_user2interface, in, 1, user data valid.
- ack_interface2user, out, 1, ready to user; a word transfers when vld and ack are both high.
- din_leaf_bft2interface, in, PACKET_BITS, inbound control packets (config and credit).
- dout_leaf_interface2bft, out, PACKET_BITS, outbound data packets.
- bft_ready, in, 1, BFT accepts the output packet this cycle.
- cfg_done, out, 1, destination is configured.

Function
REQ-003 Packet layout SHALL be: [48] valid, [47:43] leaf, [42:39] port, [38:32] addr, [31:0] payload.
REQ-004 An inbound packet with valid=1 and port=0 SHALL be a config packet: dest_leaf=payload[8:4], dest_port=payload[3:0]; it also resets credit to 2**NUM_ADDR_BITS (128) and addr to 0.
REQ-005 An inbound packet with valid=1 and port=1 SHALL be a freespace update: credit += FREESPACE_UPDATE_SIZE, saturating at 128.
REQ-006 Inbound packets with any other port value SHALL be ignored.
REQ-007 The FSM states SHALL be UNCFG, RUN and NOCRED.
- UNCFG->RUN on a config packet.
- RUN->NOCRED when credit reaches 0.
- NOCRED->RUN when credit becomes nonzero.
- Any state returns to RUN on a config packet.
REQ-008 ack_interface2user SHALL be high only in RUN, with credit>0, and with the output register empty or bft_ready high.
REQ-009 An accepted word SHALL appear registered on dout_leaf_interface2bft the next cycle, with valid=1, dest_leaf, dest_port, the current addr, and the word as payload; latency is 1 cycle.
REQ-010 The output packet SHALL hold stable until bft_ready is sampled high; the valid bit SHALL drop on the cycle after acceptance when no new word follows.
REQ-011 Each accepted word SHALL increment addr modulo 128 (127 wraps to 0) and decrement credit by 1.
REQ-012 A credit update coinciding with an accepted word SHALL apply net +63 in the same cycle.
REQ-013 A config packet coinciding with an accepted word SHALL take precedence: credit=128 and addr=0 after that cycle, and the accepted word uses the old destination.
REQ-014 Credit SHALL be 8 bits wide and SHALL never underflow below 0 or exceed 128.

Reset
REQ-015 While ap_rst_n is low, the block SHALL be in state UNCFG with dout_leaf_interface2bft=0, ack_interface2user=0, cfg_done=0, credit=0, addr=0, dest_leaf=0 and dest_port=0.
REQ-016 Reset asserted mid-packet SHALL drop the held output packet, with no residual valid bit after release.

Structure
REQ-017 A shared package SHALL hold the field offsets and widths, the config and credit port codes (0, 1) and the FSM state enum.
REQ-018 One sub-module, leaf_credit_counter, SHALL own the saturating credit arithmetic and the zero flag.

Verification
REQ-019 Config packet with payload=0x0000_0053 -> dest_leaf=5, dest_port=3, cfg_done=1 and ack=1 on the next cycle.
REQ-020 Stream 130 words with bft_ready=1 and no updates -> 128 packets with addr 0..127; ack drops after the 128th word; state is NOCRED.
REQ-021 In NOCRED, one freespace update -> 64 further words accepted, with addr wrapping to 0..63, then a stall.
REQ-022 Hold bft_ready=0 for 5 cycles with a word pending -> the output is stable, ack=0 and no word is lost; the word is released when bft_ready=1.
REQ-023 Credit update coincident with a send at credit=1 -> credit=64 and the state stays RUN.
REQ-024 Pull ap_rst_n low while an output is pending -> outputs go to 0 immediately; after release cfg_done=0 and ack stays 0 until a config packet arrives.
